// File: rtl/tl_state_seq.sv
// Traffic-light state sequencer with left-turn phases: holds Q and the per-phase dwell counter.
// Optional macro TL_LEFT_SKIP_EN: skip a street's left phase when its left sensor is idle at yellow expiry.
module tl_state_seq #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned MIN_GRN = 4,
  parameter int unsigned MIN_LFT = 2,
  parameter int unsigned MAX_GRN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [2:0] Q
);

  typedef enum logic [2:0] {
    S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b011,
    S4 = 3'b100, S5 = 3'b101, S6 = 3'b110, S7 = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] LFT_LAST = CNT_W'(MIN_LFT - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GRN - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       seq_nx;
  logic             opp;
  logic             own_grn;
  logic             own_lft;
  logic             max_hit;

  // A-side fields are used while Q[2]=0, B-side fields while Q[2]=1.
  always_comb begin
    seq_nx   = 3'(state + 3'd1);
    opp      = state[2] ? (Ta | Tal) : (Tb | Tbl);
    own_grn  = state[2] ? Tb  : Ta;
    own_lft  = state[2] ? Tbl : Tal;
    max_hit  = (cnt >= MAX_LAST) && opp;
    state_nx = state;
    unique case (state)
      S0, S4: if ((cnt >= GRN_LAST) && (!own_grn || max_hit)) state_nx = state_t'(seq_nx);
      S2, S6: if ((cnt >= LFT_LAST) && (!own_lft || max_hit)) state_nx = state_t'(seq_nx);
      S1, S5: begin
        if (cnt == YEL_LAST) begin
`ifdef TL_LEFT_SKIP_EN
          state_nx = own_lft ? state_t'(seq_nx) : state_t'({~state[2], 2'b00});
`else
          state_nx = state_t'(seq_nx);
`endif
        end
      end
      S3, S7: if (cnt == YEL_LAST) state_nx = state_t'(seq_nx);
      default: state_nx = S0;
    endcase
  end

  // Counter saturates so the >= dwell comparisons stay true while a phase is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + CNT_W'(1);
    end
  end

  assign Q = state;

endmodule

// File: tb/tb_tl_state_seq.sv
// Self-checking bench for tl_state_seq: directed scenarios plus randomized sensors vs a phase/dwell model.
module tb_tl_state_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ta, tal, tb, tbl;
  logic [2:0] q;
  logic       s_ta, s_tal, s_tb, s_tbl;
  logic [2:0] s_q;

  int m_q, m_d, s_mq, s_md;
  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  tl_state_seq u_dut (
    .clk(clk), .reset_n(reset_n), .Ta(ta), .Tal(tal), .Tb(tb), .Tbl(tbl), .Q(q)
  );

  tl_state_seq #(.CNT_W(4), .MAX_GRN(15)) u_sat (
    .clk(clk), .reset_n(reset_n), .Ta(s_ta), .Tal(s_tal), .Tb(s_tb), .Tbl(s_tbl), .Q(s_q)
  );

  // Phase p (0..7) with d whole cycles already spent in it; returns the next phase.
  function automatic int nxt(int p, int d, logic a, logic al, logic b, logic bl, int maxg);
    logic opp, grn, lft;
    opp = (p < 4) ? (b | bl) : (a | al);
    grn = (p < 4) ? a : b;
    lft = (p < 4) ? al : bl;
    case (p % 4)
      0: if (d >= 3 && (!grn || (d >= maxg - 1 && opp))) return (p + 1) % 8;
      2: if (d >= 1 && (!lft || (d >= maxg - 1 && opp))) return (p + 1) % 8;
      1: if (d == 2) begin
`ifdef TL_LEFT_SKIP_EN
           if (!lft) return (p + 3) % 8;
`endif
           return p + 1;
         end
      default: if (d == 2) return (p + 1) % 8;
    endcase
    return p;
  endfunction

  task automatic tick();
    int n;
    @(posedge clk);
    if (!reset_n) begin
      m_q = 0; m_d = 0; s_mq = 0; s_md = 0;
    end else begin
      n = nxt(m_q, m_d, ta, tal, tb, tbl, 16);
      m_d = (n == m_q) ? m_d + 1 : 0;
      m_q = n;
      n = nxt(s_mq, s_md, s_ta, s_tal, s_tb, s_tbl, 15);
      s_md = (n == s_mq) ? s_md + 1 : 0;
      s_mq = n;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_q = 0; m_d = 0; s_mq = 0; s_md = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    ta = 0; tal = 0; tb = 0; tbl = 0;
    s_ta = 0; s_tal = 0; s_tb = 0; s_tbl = 0;
    reset_n = 1'b0;
    #2;
    chk_cnt++;
    if (q !== 3'b000) $display("FAIL reset_q got=%b exp=000", q); else pass_cnt++;
    chk_cnt++;
    if (s_q !== 3'b000) $display("FAIL reset_sat_q got=%b exp=000", s_q); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_async_mid_yellow();
    int k;
    ta = 0; tal = 0; tb = 0; tbl = 0;
    do_reset();
    k = 0;
    while (q !== 3'b001 && k < 20) begin tick(); k++; end
    chk_cnt++;
    if (q !== 3'b001) $display("FAIL reach_yellow got=%b exp=001", q); else pass_cnt++;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (q !== 3'b000) $display("FAIL async_reset got=%b exp=000", q); else pass_cnt++;
    m_q = 0; m_d = 0; s_mq = 0; s_md = 0;
    ta = 1; tb = 0; tbl = 0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_cnt++;
      if (q !== 3'b000) $display("FAIL hold_after_reset cyc=%0d got=%b exp=000", i, q); else pass_cnt++;
    end
  endtask

  task automatic test_default_cycle();
    int dw[8] = '{4, 3, 2, 3, 4, 3, 2, 3};
    int seq[$];
    int e;
    for (int p = 0; p < 8; p++)
      for (int j = 0; j < dw[p]; j++) seq.push_back(p);
    ta = 0; tal = 0; tb = 0; tbl = 0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
`ifdef TL_LEFT_SKIP_EN
      e = m_q;
`else
      e = seq[i % seq.size()];
`endif
      chk_cnt++;
      if (q !== e[2:0]) $display("FAIL default_cycle cyc=%0d got=%b exp=%b", i, q, e[2:0]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_max_green();
    int cyc, y;
    ta = 1; tal = 0; tb = 0; tbl = 0;
    do_reset();
    cyc = 0;
    while (q === 3'b000 && cyc < 100) begin
      if (cyc == 2) tb = 1;
      tick();
      cyc++;
    end
    chk_cnt++;
    if (cyc != 16) $display("FAIL max_green_dwell got=%0d exp=16", cyc); else pass_cnt++;
    y = 0;
    while (q === 3'b001 && y < 20) begin tick(); y++; end
    chk_cnt++;
    if (y != 3) $display("FAIL max_green_yellow got=%0d exp=3", y); else pass_cnt++;
  endtask

  task automatic test_min_green();
    int cyc;
    ta = 0; tal = 0; tb = 1; tbl = 0;
    do_reset();
    cyc = 0;
    while (q === 3'b000 && cyc < 100) begin
      ta = (cyc == 1);
      tick();
      cyc++;
    end
    ta = 0;
    chk_cnt++;
    if (cyc != 4) $display("FAIL min_green_dwell got=%0d exp=4", cyc); else pass_cnt++;
  endtask

`ifdef TL_LEFT_SKIP_EN
  task automatic test_left_skip();
    int k;
    ta = 0; tal = 0; tb = 0; tbl = 1;
    do_reset();
    k = 0;
    while (q !== 3'b001 && k < 20) begin tick(); k++; end
    k = 0;
    while (q === 3'b001 && k < 20) begin tick(); k++; end
    chk_cnt++;
    if (k != 3 || q !== 3'b100) $display("FAIL skip_a_left yel=%0d got=%b exp=3,100", k, q); else pass_cnt++;
    k = 0;
    while (q !== 3'b101 && k < 20) begin tick(); k++; end
    k = 0;
    while (q === 3'b101 && k < 20) begin tick(); k++; end
    chk_cnt++;
    if (q !== 3'b110) $display("FAIL b_left_taken got=%b exp=110", q); else pass_cnt++;
    for (int i = 0; i < 30; i++) tick();
    chk_cnt++;
    if (q !== 3'b110) $display("FAIL b_left_hold got=%b exp=110", q); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    int p;
    ta = 0; tal = 0; tb = 0; tbl = 0;
    do_reset();
    p = 2;
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) p = $urandom_range(0, 4);
      tick();
      ta  = ($urandom_range(0, 3) < p);
      tal = ($urandom_range(0, 3) < p);
      tb  = ($urandom_range(0, 3) < p);
      tbl = ($urandom_range(0, 3) < p);
      s_ta = $urandom_range(0, 1); s_tal = $urandom_range(0, 1);
      s_tb = $urandom_range(0, 1); s_tbl = $urandom_range(0, 1);
      #1;
      chk_cnt++;
      if (q !== m_q[2:0]) $display("FAIL random_q cyc=%0d got=%b exp=%b", i, q, m_q[2:0]); else pass_cnt++;
      chk_cnt++;
      if (s_q !== s_mq[2:0]) $display("FAIL random_sat_q cyc=%0d got=%b exp=%b", i, s_q, s_mq[2:0]); else pass_cnt++;
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (q !== 3'b000) $display("FAIL random_async_reset got=%b exp=000", q); else pass_cnt++;
        m_q = 0; m_d = 0; s_mq = 0; s_md = 0;
        reset_n = 1'b1;
      end
    end
  endtask

  task automatic test_saturation();
    s_ta = 1; s_tal = 0; s_tb = 0; s_tbl = 0;
    ta = 0; tal = 0; tb = 0; tbl = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_cnt++;
      if (s_q !== 3'b000) $display("FAIL sat_hold cyc=%0d got=%b exp=000", i, s_q); else pass_cnt++;
    end
    s_tb = 1;
    tick();
    chk_cnt++;
    if (s_q !== 3'b001) $display("FAIL sat_exit got=%b exp=001", s_q); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_async_mid_yellow();
    test_default_cycle();
    test_max_green();
    test_min_green();
`ifdef TL_LEFT_SKIP_EN
    test_left_skip();
`endif
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tl_state_seq.md
# tl_state_seq

Registered state sequencer for the traffic light controller with left-turn phases. It holds the 3-bit state `Q[2:0]` that drives the light output decoder directly downstream. Each clock it computes the next state from the four traffic sensors and a per-phase dwell counter. It enforces a minimum green, a fixed yellow, and a maximum green so that neither street is starved.

## Interface
- `CNT_W`, 8, dwell counter width.
- `YEL_CYC`, 3, exact yellow dwell in cycles.
- `MIN_GRN`, 4, minimum through-green dwell in cycles.
- `MIN_LFT`, 2, minimum left-turn dwell in cycles.
- `MAX_GRN`, 16, dwell after which a green or left phase yields if opposing demand exists.
- Legal values: all parameters ≥1 and < 2^CNT_W; `MIN_GRN` ≤ `MAX_GRN`; `MIN_LFT` ≤ `MAX_GRN`.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Ta` in 1: through traffic present on street A.
- `Tal` in 1: left-turn traffic present on street A.
- `Tb` in 1: through traffic present on street B.
- `Tbl` in 1: left-turn traffic present on street B.
- `Q` out 3: current state, fed to the light output decoder.

## Operation
- Decoder light code, for reference: 00 green, 01 yellow, 10 left, 11 red.
- State meanings:
  - S0=000: A green
  - S1=001: A yellow
  - S2=010: A left
  - S3=011: A yellow
  - S4=100: B green
  - S5=101: B yellow
  - S6=110: B left
  - S7=111: B yellow
- The B street is red whenever Q[2]=0; the A street is red whenever Q[2]=1.
- `cnt` is an internal CNT_W-bit dwell counter.
  - It is 0 in the first cycle of every state.
  - It increments each cycle the state is held.
  - It saturates at all-ones and never wraps.
- Opposing demand:
  - `oppB = Tb|Tbl` while Q[2]=0.
  - `oppA = Ta|Tal` while Q[2]=1.
- Transitions, evaluated every rising edge:
  - S0→S1 when `cnt ≥ MIN_GRN-1` and (`Ta==0` or (`cnt ≥ MAX_GRN-1` and `oppB`)). Otherwise hold.
  - S1→S2 when `cnt == YEL_CYC-1`.
  - S2→S3 when `cnt ≥ MIN_LFT-1` and (`Tal==0` or (`cnt ≥ MAX_GRN-1` and `oppB`)).
  - S3→S4 when `cnt == YEL_CYC-1`.
  - S4 through S7 mirror S0 through S3, using `Tb`, `Tbl` and `oppA`. S7→S0.
- Every transition clears `cnt` to 0.
- With no opposing demand, a green or left phase with its sensor high holds indefinitely.
- The sequence S0..S7 is strictly cyclic and no state is skipped, except under the Configuration option below.
- Sensor inputs are synchronous to `clk`. This block performs no synchronization.

## Timing
- `Q` is taken directly from flops. There is no combinational path from any input to `Q`.
- Sensors sampled at edge k affect `Q` after edge k, giving one-cycle latency.
- Reset:
  - Asserting `reset_n` low forces `Q=000` and `cnt=0` immediately, without waiting for a clock.
  - Reset in mid-phase, including mid-yellow, abandons the phase.
  - After release, the first edge treats the block as in cycle 0 of S0.
- Dwell lengths:
  - Yellow lasts exactly `YEL_CYC` cycles.
  - Green lasts at least `MIN_GRN` cycles.
  - Left lasts at least `MIN_LFT` cycles.
- Sensor changes during yellow are ignored.
- Simultaneous own-demand high and opposing demand high at `cnt == MAX_GRN-1`: the phase yields, because the max timer wins.
- Counter saturation at 2^CNT_W-1 keeps every `≥` comparison true; it does not wrap to 0.

## Configuration
- Macro: `TL_LEFT_SKIP_EN`.
- When defined: at the S1 yellow expiry, if `Tal==0`, go S1→S4 and skip S2 and S3. Likewise S5→S0 when `Tbl==0`.
  - `Tal`/`Tbl` are sampled on the same edge that ends the yellow.
  - If the left sensor is high at that edge, the normal path is taken.
- When undefined: S1→S2 and S5→S6 always, and left phases last at least `MIN_LFT` cycles even with no demand.

## Test plan
- Reset mid-S1, asynchronously between edges: `Q` goes to 000 at once, without a clock. After release with `Ta=1`, `Tb=Tbl=0`, `Q` stays 000 for 50 cycles.
- Defaults, all sensors 0, macro undefined: `Q` follows this dwell sequence, repeating:
  - 000 ×4
  - 001 ×3
  - 010 ×2
  - 011 ×3
  - 100 ×4
  - 101 ×3
  - 110 ×2
  - 111 ×3
- Max green: `Ta=1` held, `Tb` raised at cycle 2 of S0. `Q` leaves 000 after exactly 16 cycles in S0, then shows 001 for 3 cycles.
- Min green: `Ta=0` from reset, `Tb=1`. `Q=000` for exactly 4 cycles. A `Ta` pulse at cycle 1 does not extend the dwell.
- `TL_LEFT_SKIP_EN` defined, `Tal=0`, `Tbl=1`:
  - S1 (3 cycles) is followed directly by 100.
  - S5 is followed by 110, which holds while `Tbl=1` (up to `MAX_GRN` if `Ta` is high).
- Saturation, `CNT_W=4`, `MAX_GRN=15`, `Ta=1`, no opposing demand for 40 cycles: `Q` stays 000. Raising `Tb` causes exit on the next edge.
